// File: rtl/jk_bank_sequencer_if.sv
// Command/status bundle between a requester and the JK bank sequencer.
// The requester drives commands and abort; the sequencer reports ready/busy/done.
interface jk_bank_sequencer_if #(
  parameter int W     = 4,
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [W-1:0]     cmd_data;
  logic [LEN_W-1:0] cmd_len;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_len, abort,
    input  cmd_ready, busy, done, aborted
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_len, abort,
    output cmd_ready, busy, done, aborted
  );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Drives the j/k pins of an external W-bit JK flip-flop bank so it acts as a
// clearable/loadable up/down counter, executing commands from a valid/ready port.
module jk_bank_sequencer #(
  parameter int W     = 4,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  jk_bank_sequencer_if.slave   cmd,
  input  logic [W-1:0]         q_in,
  output logic [W-1:0]         j,
  output logic [W-1:0]         k
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     data_q, data_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  // Toggle masks: bit i flips when every lower bit is 1 (up) or 0 (down).
  logic [W-1:0] up_t;
  logic [W-1:0] dn_t;

  for (genvar gi = 0; gi < W; gi++) begin : g_t
    if (gi == 0) begin : g_lsb
      assign up_t[gi] = 1'b1;
      assign dn_t[gi] = 1'b1;
    end else begin : g_upper
      assign up_t[gi] = &q_in[gi-1:0];
      assign dn_t[gi] = &(~q_in[gi-1:0]);
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d   = cmd.cmd_op;
          data_d = cmd.cmd_data;
          cnt_d  = cmd.cmd_len;
          // A zero-length count has nothing to drive, so it completes at once.
          if (cmd.cmd_op[1] && (cmd.cmd_len == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (!op_q[1]) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (cmd.abort) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_CLEAR;
      data_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Reset and abort gate the bank pins combinationally so that cycle's step is lost.
  always_comb begin
    j = '0;
    k = '0;
    if (!rst && (state_q == S_EXEC)) begin
      case (op_q)
        OP_CLEAR: k = '1;
        OP_LOAD: begin
          j = data_q;
          k = ~data_q;
        end
        OP_UP: begin
          if (!cmd.abort) begin
            j = up_t;
            k = up_t;
          end
        end
        default: begin
          if (!cmd.abort) begin
            j = dn_t;
            k = dn_t;
          end
        end
      endcase
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE) && !rst;
  assign cmd.busy      = (state_q != S_IDLE);
  assign cmd.done      = done_q;
  assign cmd.aborted   = aborted_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: a behavioural JK bank closes the loop and an
// arithmetic model (start +/- steps mod 2^W) predicts q, j/k and handshake timing.
module tb_jk_bank_sequencer;
  localparam int W     = 4;
  localparam int LEN_W = 8;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] q_in;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] bank_q = '0;

  int n_tests = 0;
  int n_fail  = 0;

  jk_bank_sequencer_if #(.W(W), .LEN_W(LEN_W)) bus ();

  jk_bank_sequencer #(.W(W), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (bus.slave),
    .q_in (q_in),
    .j    (j),
    .k    (k)
  );

  always #5 clk = ~clk;

  // External JK flip-flop bank sharing the clock.
  always @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b01:   bank_q[i] <= 1'b0;
        2'b10:   bank_q[i] <= 1'b1;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: bank_q[i] <= bank_q[i];
      endcase
    end
  end
  assign q_in = bank_q;

  task automatic send(input logic [1:0] op, input logic [W-1:0] data,
                      input logic [LEN_W-1:0] len, output bit ok);
    ok = 1'b0;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    $display("[TB] cmd op=%0d data=%h len=%0d accepted=%0d", op, data, len, ok);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!bus.busy) ok = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++; if (j !== '0 || k !== '0) begin n_fail++; $display("FAIL reset_jk: j=%b k=%b want 0/0", j, k); end
    n_tests++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b want 0", bus.cmd_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
    n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: busy=%b done=%b aborted=%b want 0/0/0", bus.busy, bus.done, bus.aborted); end
    @(posedge clk); #1;
    $display("[TB] reset done");
  endtask

  task automatic test_clear();
    bit ok;
    send(OP_LOAD, 4'b0110, '0, ok);
    wait_idle(ok);
    send(OP_CLEAR, 4'b1001, '0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL clear_accept: got 0 want 1"); end
    bus.abort = 1'b1;
    @(negedge clk);
    n_tests++; if (j !== '0 || k !== {W{1'b1}}) begin n_fail++; $display("FAIL clear_jk: j=%b k=%b want 0000/1111", j, k); end
    n_tests++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL clear_busy: busy=%b ready=%b want 1/0", bus.busy, bus.cmd_ready); end
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    n_tests++; if (q_in !== '0) begin n_fail++; $display("FAIL clear_q: got %b want 0000", q_in); end
    n_tests++; if (bus.done !== 1'b1 || bus.aborted !== 1'b0) begin
      n_fail++; $display("FAIL clear_done: done=%b aborted=%b want 1/0", bus.done, bus.aborted); end
    n_tests++; if (bus.cmd_ready !== 1'b0 || j !== '0 || k !== '0) begin
      n_fail++; $display("FAIL clear_done_hold: ready=%b j=%b k=%b want 0/0/0", bus.cmd_ready, j, k); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL clear_ready_back: ready=%b done=%b want 1/0", bus.cmd_ready, bus.done); end
    @(posedge clk); #1;
  endtask

  // Loads start, then runs a count, checking every cycle against start +/- steps.
  task automatic test_count(input bit down, input logic [W-1:0] start,
                            input int len, input int abort_at);
    logic [W-1:0] expq;
    logic [W-1:0] t;
    int           applied;
    int           dcyc;
    int           m;
    bit           ab;
    bit           ok;
    send(OP_LOAD, start, '0, ok);
    wait_idle(ok);
    n_tests++; if (q_in !== start) begin n_fail++; $display("FAIL load_q: got %b want %b", q_in, start); end
    ab      = (abort_at >= 0) && (abort_at < len);
    applied = ab ? abort_at : len;
    dcyc    = ab ? abort_at + 1 : len;
    send(down ? OP_DOWN : OP_UP, '0, LEN_W'(len), ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL count_accept: got 0 want 1"); end
    for (int c = 0; c <= dcyc; c++) begin
      bus.abort = (c == abort_at);
      @(negedge clk);
      m    = (c < applied) ? c : applied;
      expq = down ? start - W'(m) : start + W'(m);
      if (c < dcyc) begin
        if (ab && c == abort_at) t = '0;
        else t = expq ^ (down ? expq - W'(1) : expq + W'(1));
        n_tests++; if (j !== t || k !== t) begin n_fail++; $display("FAIL count_jk c=%0d: j=%b k=%b want %b", c, j, k, t); end
        n_tests++; if (q_in !== expq) begin n_fail++; $display("FAIL count_q c=%0d: got %b want %b", c, q_in, expq); end
        n_tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          n_fail++; $display("FAIL count_status c=%0d: done=%b busy=%b want 0/1", c, bus.done, bus.busy); end
      end else begin
        n_tests++; if (bus.done !== 1'b1 || bus.aborted !== ab) begin
          n_fail++; $display("FAIL count_done c=%0d: done=%b aborted=%b want 1/%b", c, bus.done, bus.aborted, ab); end
        n_tests++; if (q_in !== expq) begin n_fail++; $display("FAIL count_final_q: got %b want %b", q_in, expq); end
        n_tests++; if (j !== '0 || k !== '0) begin n_fail++; $display("FAIL count_done_jk: j=%b k=%b want 0/0", j, k); end
      end
      @(posedge clk); #1;
    end
    bus.abort = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL count_after: done=%b ready=%b want 0/1", bus.done, bus.cmd_ready); end
    @(posedge clk); #1;
    $display("[TB] count down=%0d start=%b len=%0d abort_at=%0d q=%b", down, start, len, abort_at, q_in);
  endtask

  task automatic test_count_up();   test_count(1'b0, 4'b1010, 7, -1);  endtask
  task automatic test_count_down(); test_count(1'b1, 4'b0010, 5, -1);  endtask
  task automatic test_len0();       test_count(1'b0, 4'b0110, 0, -1);  endtask
  task automatic test_abort();      test_count(1'b0, 4'b0000, 10, 3);  endtask

  task automatic test_reset_mid();
    bit           ok;
    logic [W-1:0] expq;
    send(OP_LOAD, 4'b1001, '0, ok);
    wait_idle(ok);
    expq = 4'b1001 + 4'd5;
    send(OP_UP, '0, LEN_W'(20), ok);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (j !== '0 || k !== '0) begin n_fail++; $display("FAIL rstmid_jk: j=%b k=%b want 0/0", j, k); end
    n_tests++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", bus.cmd_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        n_fail++; $display("FAIL rstmid_status c=%0d: done=%b busy=%b ready=%b want 0/0/1", c, bus.done, bus.busy, bus.cmd_ready); end
      n_tests++; if (q_in !== expq) begin n_fail++; $display("FAIL rstmid_q c=%0d: got %b want %b", c, q_in, expq); end
      @(posedge clk); #1;
    end
    $display("[TB] reset mid-count q=%b", q_in);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int done_c;
    int acc_c;
    done_c = -1;
    acc_c  = -1;
    send(OP_UP, '0, LEN_W'(3), ok);
    bus.cmd_op    = OP_LOAD;
    bus.cmd_data  = 4'b0101;
    bus.cmd_len   = '0;
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 20 && acc_c < 0; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_c = c;
      if (bus.cmd_ready === 1'b1) acc_c = c;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    n_tests++; if (done_c != 3) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d want 3", done_c); end
    n_tests++; if (acc_c != 4) begin n_fail++; $display("FAIL b2b_accept_cycle: got %0d want 4", acc_c); end
    wait_idle(ok);
    n_tests++; if (q_in !== 4'b0101) begin n_fail++; $display("FAIL b2b_q: got %b want 0101", q_in); end
    $display("[TB] held command accepted at cycle %0d", acc_c);
  endtask

  task automatic test_random();
    bit           down;
    logic [W-1:0] start;
    int           len;
    int           ab_at;
    for (int it = 0; it < 25; it++) begin
      down  = 1'($urandom_range(0, 1));
      start = W'($urandom);
      len   = int'($urandom_range(0, 12));
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len + 1)) : -1;
      test_count(down, start, len, ab_at);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_CLEAR;
    bus.cmd_data  = '0;
    bus.cmd_len   = '0;
    bus.abort     = 1'b0;
    test_reset();
    test_clear();
    test_count_up();
    test_count_down();
    test_len0();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
